// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI ALU master: frame geometry, FSM states
// and the frame packing helper.
package spi_alu_pkg;

    localparam int FRAME_BITS = 12;
    localparam int NIBBLE_W   = 4;

    localparam logic HANDSHAKE_BIT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        HANDSHAKE,
        SHIFT,
        TAIL,
        GAP
    } state_t;

    function automatic logic [FRAME_BITS-1:0] packFrame(
        input logic [NIBBLE_W-1:0] op1,
        input logic [NIBBLE_W-1:0] op2,
        input logic [NIBBLE_W-1:0] opr
    );
        return {op1, op2, opr};
    endfunction

endpackage

// File: rtl/spi_alu_master_if.sv
// Command/status and SPI pin bundle between the ALU master and its surroundings.
// The master modport is the block's own view; the slave modport is the environment's.
interface spi_alu_master_if;
    import spi_alu_pkg::*;

    logic                start;
    logic [NIBBLE_W-1:0] operando_1;
    logic [NIBBLE_W-1:0] operando_2;
    logic [NIBBLE_W-1:0] operador;
    logic                MISO;
    logic                SCLK;
    logic                MOSI;
    logic                CS;
    logic                busy;
    logic                done;
    logic                ack_error;

    modport master (
        input  start, operando_1, operando_2, operador, MISO,
        output SCLK, MOSI, CS, busy, done, ack_error
    );

    modport slave (
        output start, operando_1, operando_2, operador, MISO,
        input  SCLK, MOSI, CS, busy, done, ack_error
    );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider. Strobes flag the clock whose edge will raise or lower SCLK,
// so the FSM can act on the same edge as the SCLK transition.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic stop_i,
    output logic sclk_o,
    output logic riseNext_o,
    output logic fall_o
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             halfEnd;

    assign halfEnd    = en_i && (cnt_q == CNT_LAST);
    assign riseNext_o = halfEnd && !sclk_q;
    assign fall_o     = halfEnd && sclk_q;
    assign sclk_o     = sclk_q;

    // stop_i overrides a pending rising edge so an aborted frame never shows that edge
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        sclk_d = sclk_q;
        if (!en_i || stop_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (halfEnd) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_alu_master.sv
// SPI master sending one handshake bit plus a 12-bit ALU command frame, checking the
// slave's MISO acknowledge before the first data bit is clocked in.
module spi_alu_master
    import spi_alu_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int TAIL_SLOTS = 2
) (
    input  logic              clk_arduino,
    input  logic              reset,
    spi_alu_master_if.master  bus
);

    localparam int LAST_SLOT = FRAME_BITS + TAIL_SLOTS;
    localparam int SLOT_W    = $clog2(LAST_SLOT + 1);
    localparam int GAP_CLKS  = 2 * CLK_DIV;
    localparam int GAP_W     = $clog2(GAP_CLKS);

    state_t                  state_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [SLOT_W-1:0]       slot_q;
    logic [GAP_W-1:0]        gapCnt_q;
    logic                    sclkEn_q;
    logic                    csN_q;
    logic                    mosi_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    ackErr_q;

    logic                    sclk;
    logic                    riseNext;
    logic                    fall;
    logic                    abortNow;
    logic                    endNow;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i      (clk_arduino),
        .rst_n_i    (reset),
        .en_i       (sclkEn_q),
        .stop_i     (abortNow),
        .sclk_o     (sclk),
        .riseNext_o (riseNext),
        .fall_o     (fall)
    );

    // The acknowledge is judged on the clock that would otherwise raise SCLK in slot 1
    assign abortNow = (state_q == SHIFT) && (slot_q == SLOT_W'(1)) && riseNext && !bus.MISO;
    assign endNow   = fall && (slot_q == SLOT_W'(LAST_SLOT))
                    && ((state_q == SHIFT) || (state_q == TAIL));

    always_ff @(posedge clk_arduino or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            slot_q   <= '0;
            gapCnt_q <= '0;
            sclkEn_q <= 1'b0;
            csN_q    <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ackErr_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            ackErr_q <= 1'b0;
            if (abortNow || endNow) begin
                sclkEn_q <= 1'b0;
                csN_q    <= 1'b1;
                mosi_q   <= 1'b0;
                done_q   <= 1'b1;
                ackErr_q <= abortNow;
                gapCnt_q <= '0;
                state_q  <= GAP;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            shift_q <= packFrame(bus.operando_1, bus.operando_2, bus.operador);
                            slot_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= HANDSHAKE;
                        end
                    end
                    HANDSHAKE: begin
                        // First cycle after accept opens the frame; SCLK starts its low half here
                        if (!sclkEn_q) begin
                            sclkEn_q <= 1'b1;
                            csN_q    <= 1'b0;
                            mosi_q   <= HANDSHAKE_BIT;
                        end else if (fall) begin
                            slot_q  <= SLOT_W'(1);
                            mosi_q  <= shift_q[FRAME_BITS-1];
                            shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (fall) begin
                            slot_q <= slot_q + SLOT_W'(1);
                            if (slot_q < SLOT_W'(FRAME_BITS)) begin
                                mosi_q  <= shift_q[FRAME_BITS-1];
                                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            end else begin
                                mosi_q  <= 1'b0;
                                state_q <= TAIL;
                            end
                        end
                    end
                    TAIL: begin
                        if (fall) begin
                            slot_q <= slot_q + SLOT_W'(1);
                        end
                    end
                    GAP: begin
                        if (gapCnt_q == GAP_W'(GAP_CLKS - 1)) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            gapCnt_q <= gapCnt_q + GAP_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.SCLK      = sclk;
    assign bus.CS        = csN_q;
    assign bus.MOSI      = mosi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ack_error = ackErr_q;

endmodule
